// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//
// Multi-cycle unsigned multiply (MULTU) and divide (DIVU) unit. Instead of a
// dedicated multiplier/divider it borrows the shared 32-bit ALU. Each cycle it
// issues one add or subtract, for 32 iterations. It keeps the shift registers
// and the iteration counter internally. The final HI/LO words are published
// for MFHI/MFLO, and busy_o tells the control unit to stall the pipeline.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   start_i          operation request, sampled only while idle
//   op_i             0 = MULTU, 1 = DIVU (sampled together with start_i)
//   rs_data_i        multiplicand / dividend
//   rt_data_i        multiplier / divisor
//   alu_result_i     combinational result coming back from the ALU
//   alu_operation_o  ALU opcode (ADD while idle/multiplying, SUB while dividing)
//   alu_a_o          ALU operand A
//   alu_b_o          ALU operand B
//   alu_shamt_o      ALU shift amount, always zero
//   busy_o           high while iterating and in the completion cycle
//   done_o           one-cycle completion pulse
//   hi_o             product high word / remainder
//   lo_o             product low word / quotient
module mult_div_sequencer #(
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 6,
    parameter logic [4:0]  ALU_ADD    = 5'b00000,
    parameter logic [4:0]  ALU_SUB    = 5'b00001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  op_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic [4:0]            alu_operation_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [4:0]            alu_shamt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  op_div;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [DATA_WIDTH-1:0] operand;
    // acc_hi / remainder share one register, and acc_lo / quotient share another.
    logic [DATA_WIDTH-1:0] work_hi;
    logic [DATA_WIDTH-1:0] work_lo;
    logic [DATA_WIDTH-1:0] next_hi;
    logic [DATA_WIDTH-1:0] next_lo;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  carry;
    logic                  sub_ok;
    logic                  last_iter;

    assign alu_shamt_o = '0;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign last_iter   = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, ALU operand selection and the per-iteration step.
    //
    // Multiply: add the multiplicand to the high accumulator when the current
    // multiplier bit is set. The add's carry-out is recovered from the wrapped
    // result and shifted back in as the new top bit.
    //
    // Divide (restoring): the partial remainder is really 33 bits wide. If the
    // bit shifted out of rem[31] is set, the subtraction must succeed, and the
    // 32-bit wrapped difference is still the correct remainder.
    always_comb begin
        next_state      = state;
        alu_operation_o = ALU_ADD;
        alu_a_o         = '0;
        alu_b_o         = '0;
        shifted         = {work_hi[DATA_WIDTH-2:0], work_lo[DATA_WIDTH-1]};
        carry           = 1'b0;
        sub_ok          = 1'b0;
        next_hi         = work_hi;
        next_lo         = work_lo;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (op_i && (rt_data_i == '0)) begin
                        next_state = DONE;
                    end else begin
                        next_state = ITER;
                    end
                end
            end
            ITER: begin
                if (op_div) begin
                    alu_operation_o = ALU_SUB;
                    alu_a_o         = shifted;
                    alu_b_o         = operand;
                    sub_ok          = work_hi[DATA_WIDTH-1] | (shifted >= operand);
                    next_hi         = sub_ok ? alu_result_i : shifted;
                    next_lo         = {work_lo[DATA_WIDTH-2:0], sub_ok};
                end else begin
                    alu_operation_o = ALU_ADD;
                    alu_a_o         = work_hi;
                    alu_b_o         = work_lo[0] ? operand : '0;
                    carry           = (alu_result_i < work_hi);
                    {next_hi, next_lo} = {carry, alu_result_i, work_lo[DATA_WIDTH-1:1]};
                end
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Working registers, counter and the published HI/LO results. A start is
    // only honoured in IDLE, so requests made while busy are simply dropped.
    // Division by zero skips the iterations and publishes the dividend as HI
    // and all-ones as LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            op_div  <= 1'b0;
            operand <= '0;
            work_hi <= '0;
            work_lo <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_div  <= op_i;
                        cnt     <= '0;
                        work_hi <= '0;
                        if (op_i) begin
                            operand <= rt_data_i;
                            work_lo <= rs_data_i;
                            if (rt_data_i == '0) begin
                                hi_o <= rs_data_i;
                                lo_o <= '1;
                            end
                        end else begin
                            operand <= rs_data_i;
                            work_lo <= rt_data_i;
                        end
                    end
                end
                ITER: begin
                    work_hi <= next_hi;
                    work_lo <= next_lo;
                    cnt     <= cnt + 1'b1;
                    if (last_iter) begin
                        hi_o <= next_hi;
                        lo_o <= next_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer
//
// Self-checking bench for mult_div_sequencer. The bench models the ALU as a
// plain combinational add/sub. Each result is compared against a reference
// computed with 64-bit multiply, '/' and '%'.
module tb_mult_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_result;
    logic [4:0]  alu_operation;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start),
        .op_i            (op),
        .rs_data_i       (rs_data),
        .rt_data_i       (rt_data),
        .alu_result_i    (alu_result),
        .alu_operation_o (alu_operation),
        .alu_a_o         (alu_a),
        .alu_b_o         (alu_b),
        .alu_shamt_o     (alu_shamt),
        .busy_o          (busy),
        .done_o          (done),
        .hi_o            (hi),
        .lo_o            (lo)
    );

    always #5 clk = ~clk;

    // Combinational ALU: opcode 1 subtracts, anything else adds.
    assign alu_result = (alu_operation == 5'b00001) ? (alu_a - alu_b) : (alu_a + alu_b);

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic is_div, input logic [31:0] a,
                                               input logic [31:0] b);
        if (!is_div) begin
            return 64'(a) * 64'(b);
        end else if (b == 32'd0) begin
            return {a, 32'hFFFFFFFF};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    // Issues one request at #1 after an edge with the DUT idle, then waits
    // (bounded) for done_o. lat counts edges from the sampling edge until
    // done_o is seen; -1 means done_o never came.
    task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cycles, output int iter_cycles,
                         output int bad_opcode, output int nonzero_b,
                         output logic [31:0] early_hi, output logic [31:0] early_lo);
        start = 1'b1;
        op = is_div;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        iter_cycles = 0;
        bad_opcode = 0;
        nonzero_b = 0;
        early_hi = hi;
        early_lo = lo;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            iter_cycles++;
            if (alu_operation !== (is_div ? 5'b00001 : 5'b00000)) bad_opcode++;
            if (alu_b !== 32'd0) nonzero_b++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (done) begin
            if (busy) busy_cycles++;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        op = 1'b0;
        rs_data = '0;
        rt_data = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_result: hi=%h lo=%h expected 0 0", hi, lo);
        end
        checks++;
        if (alu_operation !== 5'b00000 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_shamt !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_alu: op=%b a=%h b=%h shamt=%0d expected 00000 0 0 0",
                     alu_operation, alu_a, alu_b, alu_shamt);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_multu_edges();
        int lat, bc, ic, bad, nzb;
        logic [31:0] eh, el;
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("[TB] FAIL mul_max_latency: got %0d expected 33", lat);
        end
        checks++;
        if (bc !== 33) begin
            errors++;
            $display("[TB] FAIL mul_max_busy: got %0d cycles expected 33", bc);
        end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++;
            $display("[TB] FAIL mul_max_result: hi=%h lo=%h expected fffffffe 00000001", hi, lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse: done=%b busy=%b expected 0 0", done, busy);
        end
        do_op(1'b0, 32'h00012345, 32'h00000000, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mul_zero_result: hi=%h lo=%h expected 0 0", hi, lo);
        end
        checks++;
        if (nzb !== 0 || bad !== 0 || ic !== 32) begin
            errors++;
            $display("[TB] FAIL mul_zero_alu: nonzero_b=%0d bad_op=%0d iters=%0d expected 0 0 32",
                     nzb, bad, ic);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu();
        int lat, bc, ic, bad, nzb;
        logic [31:0] eh, el;
        do_op(1'b1, 32'd100, 32'd7, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("[TB] FAIL div_100_7: hi=%0d lo=%0d expected 2 14", hi, lo);
        end
        checks++;
        if (bad !== 0 || ic !== 32) begin
            errors++;
            $display("[TB] FAIL div_opcode: bad_op=%0d iters=%0d expected 0 32", bad, ic);
        end
        @(posedge clk);
        #1;
        do_op(1'b1, 32'hFFFFFFFF, 32'h80000000, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (hi !== 32'h7FFFFFFF || lo !== 32'd1) begin
            errors++;
            $display("[TB] FAIL div_rem31: hi=%h lo=%h expected 7fffffff 00000001", hi, lo);
        end
        @(posedge clk);
        #1;
        do_op(1'b1, 32'd5, 32'd0, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL div0_latency: got %0d expected 1", lat);
        end
        checks++;
        if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL div0_result: hi=%h lo=%h expected 00000005 ffffffff", hi, lo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, bc, ic, bad, nzb;
        logic [31:0] eh, el, a, b;
        logic        is_div;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            is_div = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 15);
                1: b = 32'd0;
                default: b = $urandom;
            endcase
            if (i % 5 == 4) a = 32'hFFFFFFFF - $urandom_range(0, 3);
            exp = ref_result(is_div, a, b);
            do_op(is_div, a, b, lat, bc, ic, bad, nzb, eh, el);
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h expected %h %h",
                         i, is_div, a, b, hi, lo, exp[63:32], exp[31:0]);
            end
            checks++;
            if (lat !== ((is_div && b == 32'd0) ? 1 : 33)) begin
                errors++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d",
                         i, lat, (is_div && b == 32'd0) ? 1 : 33);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        start = 1'b1;
        op = 1'b0;
        rs_data = 32'd3;
        rt_data = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        repeat (9) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b1;
        op = 1'b1;
        rs_data = 32'd9;
        rt_data = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("[TB] FAIL busy_ignore_latency: got %0d expected 33", cyc);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            errors++;
            $display("[TB] FAIL busy_ignore_result: hi=%h lo=%h expected 0 0000000c", hi, lo);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || lo !== 32'd12) begin
            errors++;
            $display("[TB] FAIL busy_ignore_noqueue: busy=%b lo=%h expected 0 0000000c", busy, lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, ic, bad, nzb;
        logic [31:0] eh, el;
        start = 1'b1;
        op = 1'b1;
        rs_data = 32'd1000;
        rt_data = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                     busy, done, hi, lo);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op(1'b0, 32'd6, 32'd7, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42 || lat !== 33) begin
            errors++;
            $display("[TB] FAIL after_reset_mul: hi=%h lo=%0d lat=%0d expected 0 42 33", hi, lo, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc, ic, bad, nzb;
        logic [31:0] eh, el;
        do_op(1'b1, 32'd1234567, 32'd1000, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (hi !== 32'd567 || lo !== 32'd1234) begin
            errors++;
            $display("[TB] FAIL b2b_first: hi=%0d lo=%0d expected 567 1234", hi, lo);
        end
        @(posedge clk);
        #1;
        do_op(1'b0, 32'h10000, 32'h30000, lat, bc, ic, bad, nzb, eh, el);
        checks++;
        if (eh !== 32'd567 || el !== 32'd1234) begin
            errors++;
            $display("[TB] FAIL b2b_hold: hi=%0d lo=%0d expected 567 1234", eh, el);
        end
        checks++;
        if (hi !== 32'd3 || lo !== 32'd0 || lat !== 33) begin
            errors++;
            $display("[TB] FAIL b2b_second: hi=%h lo=%h lat=%0d expected 3 0 33", hi, lo, lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_multu_edges();
        test_divu();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
